regfile_wport_arb: RTL and testbench
====================================

// Module: regfile_wport_arb
// PURPOSE
// - Shares the single regfile write port (wvalid/wa/wd) between two sources:
//   - the in-order pipeline writeback;
//   - results from the multi-cycle mul/div unit (MDU).
// - Buffers MDU results in a small FIFO.
// - Keeps a per-register busy scoreboard so issue logic can stall on RAW/WAW
//   hazards against outstanding MDU ops.
// - Forces a write slot for the FIFO if the pipeline monopolises the port.
// - Sits between the execute/writeback stages and regfile.
// PARAMETERS
// - DEPTH       2  MDU result FIFO entries; power of two, >=2
// - STARVE_MAX  4  cycles a non-empty FIFO may wait before pipe_stall asserts
// PORTS
// - clk           in   1   clock
// - reset         in   1   synchronous, active-high
// - pipe_valid    in   1   pipeline writeback request
// - pipe_wa       in   5   pipeline destination register
// - pipe_wd       in   64  pipeline write data
// - pipe_stall    out  1   pipeline writeback not taken this cycle; hold it
// - mdu_valid     in   1   MDU result valid
// - mdu_ready     out  1   FIFO can accept (registered, = !full)
// - mdu_wa        in   5   MDU destination register
// - mdu_wd        in   64  MDU result data
// - sb_set_valid  in   1   an MDU op issues this cycle
// - sb_set_rd     in   5   its destination register
// - ra1, ra2      in   5   issue-stage source registers to check
// - busy1, busy2  out  1   ra1/ra2 has an outstanding MDU write
// - wvalid        out  1   to regfile write enable
// - wa            out  5   to regfile write address
// - wd            out  64  to regfile write data
// BEHAVIOUR
// - Reset: FIFO empty, busy[31:0]=0, wait_cnt=0.
//   - While reset is high: mdu_ready=0, pipe_stall=0, wvalid=0.
//   - Reset mid-operation discards buffered results; no write occurs.
// - Push: on mdu_valid&&mdu_ready.
//   - mdu_wa==0 is accepted but not enqueued.
//   - A pushed entry is eligible to pop from the next cycle (no same-cycle bypass).
// - Arbitration, combinational from registered state and pipe inputs:
//   - force = (wait_cnt>=STARVE_MAX) && !empty; pipe_stall = force.
//   - force=1: pop head. wvalid=1, wa/wd = head. Pipeline request ignored.
//   - else pipe_valid=1: wvalid=1, wa/wd = pipe_*. Zero-latency passthrough.
//   - else !empty: pop head.
//   - else wvalid=0, wa=0, wd=0.
// - Simultaneous push and pop on a full FIFO is legal: count is unchanged.
//   mdu_ready still reads 0 that cycle because it is registered.
// - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
// - Starvation counter wait_cnt:
//   - cleared on a pop or when the FIFO is empty;
//   - otherwise incremented, saturating at STARVE_MAX.
// - Pipe contract: while pipe_stall=1, the pipeline holds pipe_valid/wa/wd stable.
// - Scoreboard:
//   - sb_set_valid && sb_set_rd!=0 sets busy[rd] at the clock edge.
//   - A FIFO pop clears busy[wa] at the same edge the regfile writes.
//   - Set and clear of the same register in one cycle: set wins.
//   - busy1=busy[ra1], busy2=busy[ra2]. Register 0 always reads not busy.
//   - A pipeline write never touches busy; issue logic prevents WAW.
// STRUCTURE
// - pipes package: typedef wb_req_t {logic valid; creg_addr_t wa; word_t wd;}.
//   Shared by the pipe, MDU and regfile sides.
// - Sub-module wb_fifo: parameterised DEPTH, wb_req_t payload, push/pop/full/empty.
// - Top level holds the arbiter mux, starvation counter and scoreboard.
// TESTING
// - Pipe only: pipe_valid=1, wa=5, wd=0xAA.
//   -> Same cycle wvalid=1, wa=5, wd=0xAA. pipe_stall=0.
// - MDU alone: sb_set rd=7; 3 cycles later push wa=7, wd=0x1234; no pipe traffic.
//   -> busy[7]=1 from the set edge.
//   -> Write of 7/0x1234 in the cycle after the push.
//   -> busy1 (ra1=7) drops the next cycle.
// - Starvation: push one entry, hold pipe_valid=1 continuously.
//   -> pipe_stall=1 exactly 4 cycles after the entry becomes eligible.
//   -> FIFO entry written that cycle; pipe write lands the cycle after.
// - Full: push 2 entries while pipe_valid=1 holds the port.
//   -> mdu_ready=0; a third mdu_valid is not accepted.
//   -> After one pop, mdu_ready=1 the next cycle.
// - x0 and set/clear collision:
//   - push wa=0 -> accepted, no regfile write.
//   - Pop wa=9 while sb_set rd=9 in the same cycle -> busy[9]=1 afterwards.
// - Reset with 2 entries buffered and busy[3]=1.
//   -> Next cycle empty, busy=0, wvalid=0, mdu_ready=1 once reset drops.

Source files
------------

// File: rtl/regfile_wport_arb_pkg.sv
// Shared writeback types for the regfile write-port arbiter.
// Used by the pipeline, MDU and regfile sides.
package regfile_wport_arb_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  typedef logic [4:0]      creg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t wa;
    word_t      wd;
  } wb_req_t;

  localparam wb_req_t WB_IDLE = '{
    valid: 1'b0,
    wa:    '0,
    wd:    '0
  };

  function automatic wb_req_t mk_req(
    input logic       v,
    input creg_addr_t a,
    input word_t      d
  );
    wb_req_t r;
    r.valid = v;
    r.wa    = a;
    r.wd    = d;
    return r;
  endfunction

endpackage

// File: rtl/regfile_wport_arb_wb_fifo.sv
// Small result FIFO for MDU writebacks.
// Registered ready flag so the MDU sees a clean accept signal.
import regfile_wport_arb_pkg::*;

module regfile_wport_arb_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty,
  output logic    ready
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  wb_req_t mem [DEPTH];

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;
  cnt_t count_nxt;
  logic do_push;
  logic do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    unique case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Pointers, count and registered ready; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      ready <= (count_nxt != CNT_FULL);
    end
  end

  // Payload storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wport_arb.sv
// Regfile write-port arbiter: pipeline writeback vs buffered MDU results.
// Holds the starvation counter and the MDU busy scoreboard.
import regfile_wport_arb_pkg::*;

module regfile_wport_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_wa,
  input  logic [63:0] pipe_wd,
  output logic        pipe_stall,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_wa,
  input  logic [63:0] mdu_wd,
  input  logic        sb_set_valid,
  input  logic [4:0]  sb_set_rd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        busy1,
  output logic        busy2,
  output logic        wvalid,
  output logic [4:0]  wa,
  output logic [63:0] wd
);

  localparam int WW = $clog2(STARVE_MAX + 1);

  typedef logic [WW-1:0] wcnt_t;

  localparam wcnt_t WAIT_MAX = wcnt_t'(STARVE_MAX);
  localparam wcnt_t WAIT_ONE = wcnt_t'(1);

  wb_req_t        pipe_req;
  wb_req_t        mdu_req;
  wb_req_t        head;
  wb_req_t        wr;
  logic           full;
  logic           empty;
  logic           fifo_ready;
  logic           push_acc;
  logic           push_en;
  logic           pop_en;
  logic           force_slot;
  wcnt_t          wait_cnt;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  assign pipe_req = mk_req(pipe_valid, pipe_wa, pipe_wd);
  assign mdu_req  = mk_req(1'b1, mdu_wa, mdu_wd);

  assign mdu_ready  = fifo_ready && !reset;
  assign push_acc   = mdu_valid && mdu_ready;
  assign push_en    = push_acc && (mdu_wa != '0);

  assign force_slot = (wait_cnt >= WAIT_MAX) && !empty;
  assign pipe_stall = force_slot && !reset;
  assign pop_en     = !reset && !empty
                    && (force_slot || !pipe_valid);

  regfile_wport_arb_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_en && (!full || pop_en)),
    .push_data (mdu_req),
    .pop       (pop_en),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .ready     (fifo_ready)
  );

  // Write-port mux: forced FIFO slot, then pipeline, then idle FIFO drain.
  always_comb begin
    wr = WB_IDLE;
    priority case (1'b1)
      reset:      wr = WB_IDLE;
      force_slot: wr = head;
      pipe_valid: wr = pipe_req;
      !empty:     wr = head;
      default:    wr = WB_IDLE;
    endcase
  end

  assign wvalid = wr.valid;
  assign wa     = wr.wa;
  assign wd     = wr.wd;

  // Cycles the FIFO head has waited for the port, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (pop_en || empty) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + WAIT_ONE;
    end
  end

  // Scoreboard next state: pop clears, a new issue sets and wins.
  always_comb begin
    busy_nxt = busy;
    if (pop_en) busy_nxt[head.wa] = 1'b0;
    if (sb_set_valid && (sb_set_rd != '0))
      busy_nxt[sb_set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Per-register outstanding-MDU-write flags.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign busy1 = (ra1 != '0) && busy[ra1];
  assign busy2 = (ra2 != '0) && busy[ra2];

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Bench for regfile_wport_arb: directed vectors, write scoreboard.
// A negedge monitor pops expected regfile writes and compares.
module tb_regfile_wport_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_wa;
  logic [63:0] pipe_wd;
  logic        pipe_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_wa;
  logic [63:0] mdu_wd;
  logic        sb_set_valid;
  logic [4:0]  sb_set_rd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        busy1;
  logic        busy2;
  logic        wvalid;
  logic [4:0]  wa;
  logic [63:0] wd;

  typedef struct {
    logic [4:0]  wa;
    logic [63:0] wd;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  regfile_wport_arb #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_valid   (pipe_valid),
    .pipe_wa      (pipe_wa),
    .pipe_wd      (pipe_wd),
    .pipe_stall   (pipe_stall),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_wa       (mdu_wa),
    .mdu_wd       (mdu_wd),
    .sb_set_valid (sb_set_valid),
    .sb_set_rd    (sb_set_rd),
    .ra1          (ra1),
    .ra2          (ra2),
    .busy1        (busy1),
    .busy2        (busy2),
    .wvalid       (wvalid),
    .wa           (wa),
    .wd           (wd)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [63:0] d);
    exp_t e;
    e.wa = a;
    e.wd = d;
    expq.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every regfile write must match the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b0 && wvalid === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got wa=%0d wd=%0h expected none",
                 wa, wd);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("wr_wa", 64'(wa), 64'(e.wa));
        check("wr_wd", wd, e.wd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    pipe_valid   = 1'b0;
    pipe_wa      = '0;
    pipe_wd      = '0;
    mdu_valid    = 1'b0;
    mdu_wa       = '0;
    mdu_wd       = '0;
    sb_set_valid = 1'b0;
    sb_set_rd    = '0;
    ra1          = '0;
    ra2          = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_ready", 64'(mdu_ready), 64'd0);
    check("rst_stall", 64'(pipe_stall), 64'd0);
    next();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(mdu_ready), 64'd1);
    check("post_rst_wvalid", 64'(wvalid), 64'd0);

    // Pipe only: zero-latency passthrough
    next();
    pipe_valid = 1'b1;
    pipe_wa    = 5'd5;
    pipe_wd    = 64'hAA;
    exp_wr(5'd5, 64'hAA);
    @(negedge clk);
    check("pipe_wvalid", 64'(wvalid), 64'd1);
    check("pipe_stall0", 64'(pipe_stall), 64'd0);
    next();
    pipe_valid = 1'b0;

    // MDU alone with scoreboard
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd7;
    ra1          = 5'd7;
    @(negedge clk);
    check("busy7_pre", 64'(busy1), 64'd0);
    next();
    sb_set_valid = 1'b0;
    @(negedge clk);
    check("busy7_set", 64'(busy1), 64'd1);
    next();
    @(negedge clk);
    check("busy7_hold", 64'(busy1), 64'd1);
    next();
    mdu_valid = 1'b1;
    mdu_wa    = 5'd7;
    mdu_wd    = 64'h1234;
    exp_wr(5'd7, 64'h1234);
    @(negedge clk);
    check("mdu_ready1", 64'(mdu_ready), 64'd1);
    check("no_bypass", 64'(wvalid), 64'd0);
    next();
    mdu_valid = 1'b0;
    @(negedge clk);
    check("mdu_wvalid", 64'(wvalid), 64'd1);
    check("busy7_at_pop", 64'(busy1), 64'd1);
    next();
    @(negedge clk);
    check("busy7_clr", 64'(busy1), 64'd0);
    check("mdu_idle", 64'(wvalid), 64'd0);
    next();

    // Starvation: pipe holds the port continuously
    for (int i = 0; i < 7; i++) begin
      pipe_valid = 1'b1;
      pipe_wa    = 5'd12;
      pipe_wd    = 64'h100 + 64'((i > 5) ? 5 : i);
      mdu_valid  = (i == 0);
      mdu_wa     = 5'd11;
      mdu_wd     = 64'h55;
      if (i <= 4)      exp_wr(5'd12, 64'h100 + 64'(i));
      else if (i == 5) exp_wr(5'd11, 64'h55);
      else             exp_wr(5'd12, 64'h105);
      @(negedge clk);
      check($sformatf("starve_stall%0d", i),
            64'(pipe_stall), 64'(i == 5));
      next();
    end
    pipe_valid = 1'b0;
    mdu_valid  = 1'b0;

    // Full: two pushes while pipe holds port, third rejected
    for (int i = 0; i < 6; i++) begin
      pipe_valid = (i <= 2);
      pipe_wa    = 5'd1;
      pipe_wd    = 64'(i);
      mdu_valid  = (i <= 2);
      mdu_wa     = 5'(13 + i);
      mdu_wd     = 64'hD1 + 64'(i);
      if (i <= 2)      exp_wr(5'd1, 64'(i));
      else if (i == 3) exp_wr(5'd13, 64'hD1);
      else if (i == 4) exp_wr(5'd14, 64'hD2);
      @(negedge clk);
      check($sformatf("full_ready%0d", i), 64'(mdu_ready),
            64'((i == 2 || i == 3) ? 0 : 1));
      if (i == 5) check("full_drained", 64'(wvalid), 64'd0);
      next();
    end
    pipe_valid = 1'b0;
    mdu_valid  = 1'b0;

    // x0 push and set/clear collision
    mdu_valid    = 1'b1;
    mdu_wa       = 5'd0;
    mdu_wd       = 64'hEE;
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd0;
    ra1          = 5'd9;
    ra2          = 5'd0;
    @(negedge clk);
    check("x0_ready", 64'(mdu_ready), 64'd1);
    next();
    mdu_valid    = 1'b0;
    sb_set_rd    = 5'd9;
    @(negedge clk);
    check("x0_nowrite", 64'(wvalid), 64'd0);
    check("x0_busy", 64'(busy2), 64'd0);
    next();
    sb_set_valid = 1'b0;
    mdu_valid    = 1'b1;
    mdu_wa       = 5'd9;
    mdu_wd       = 64'h99;
    exp_wr(5'd9, 64'h99);
    @(negedge clk);
    check("busy9_set", 64'(busy1), 64'd1);
    next();
    mdu_valid    = 1'b0;
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd9;
    @(negedge clk);
    check("coll_wvalid", 64'(wvalid), 64'd1);
    next();
    sb_set_valid = 1'b0;
    @(negedge clk);
    check("coll_set_wins", 64'(busy1), 64'd1);
    mdu_valid = 1'b1;
    mdu_wa    = 5'd9;
    mdu_wd    = 64'h9A;
    exp_wr(5'd9, 64'h9A);
    next();
    mdu_valid = 1'b0;
    next();
    @(negedge clk);
    check("busy9_clr", 64'(busy1), 64'd0);
    next();

    // Reset with two buffered entries and busy[3]
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd3;
    ra1          = 5'd3;
    pipe_valid   = 1'b1;
    pipe_wa      = 5'd2;
    pipe_wd      = 64'h200;
    mdu_valid    = 1'b1;
    mdu_wa       = 5'd20;
    mdu_wd       = 64'hA1;
    exp_wr(5'd2, 64'h200);
    next();
    sb_set_valid = 1'b0;
    pipe_wd      = 64'h201;
    mdu_wa       = 5'd21;
    mdu_wd       = 64'hA2;
    exp_wr(5'd2, 64'h201);
    @(negedge clk);
    check("rst2_busy3", 64'(busy1), 64'd1);
    next();
    mdu_valid  = 1'b0;
    pipe_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    check("rst2_wvalid", 64'(wvalid), 64'd0);
    check("rst2_ready", 64'(mdu_ready), 64'd0);
    check("rst2_stall", 64'(pipe_stall), 64'd0);
    next();
    reset = 1'b0;
    @(negedge clk);
    check("rst2_empty", 64'(wvalid), 64'd0);
    check("rst2_ready1", 64'(mdu_ready), 64'd1);
    check("rst2_busy_clr", 64'(busy1), 64'd0);
    next();
    @(negedge clk);
    check("rst2_idle", 64'(wvalid), 64'd0);

    check("sb_drained", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
